// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the sequential ALU (alu_seq).
//   alu_op_e    : 3-bit opcode encoding
//   alu_state_e : handshake FSM states (IDLE / BUSY / DONE)
//   FLAG_*      : bit positions inside the 4-bit {N,Z,C,V} flag vector
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NEG   = 3'b101,
    OP_SHIFT = 3'b110,
    OP_MUL   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands; the product is ready after exactly WIDTH
// clock cycles. 'done' is high during the final iteration cycle and 'product'
// then shows the completed value, so the parent can capture it on the same
// edge that retires the last iteration.
//   clk, reset : clock, synchronous active-high reset
//   start      : load a/b and begin (ignored while busy)
//   a, b       : WIDTH-bit unsigned operands
//   done       : high in the last iteration cycle
//   product    : 2*WIDTH-bit product (valid while done is high)
// -----------------------------------------------------------------------------
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done       = r_busy && (r_cnt == CW'(1));
  // Look-ahead value: equals the finished product in the last iteration cycle.
  assign product    = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// (ADD, SUB, AND, OR, XOR, NEG, SHIFT) complete one cycle after accept; MUL
// runs on the iterative multiplier for WIDTH cycles. Results are held in DONE
// until the consumer takes them.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier. Without it,
// opcode 111 completes in one cycle with result 0, result_hi 0, flags 0100.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   a, b                : operands (WIDTH bits)
//   alu_control         : opcode (see alu_seq_pkg::alu_op_e)
//   shamt, direction    : shift amount, 0 = left / 1 = logical right
//   out_valid/out_ready : result handshake
//   result, result_hi   : result (low half for MUL), MUL high half else 0
//   alu_flags           : {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  input  logic [SHW-1:0]   shamt,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       alu_flags
);

  localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic             w_shamt_ovf;
  logic [WIDTH-1:0] w_alu_result;
  logic [3:0]       w_alu_flags;

  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath. One extra bit on the shifters catches the last bit
  // shifted out (bit WIDTH for left, bit 0 for right); it is 0 when shamt==0.
  // ---------------------------------------------------------------------------
  assign w_add       = {1'b0, a} + {1'b0, b};
  assign w_sub       = {1'b0, a} - {1'b0, b};
  assign w_neg       = '0 - a;
  assign w_shl       = {1'b0, a} << shamt;
  assign w_shr       = {a, 1'b0} >> shamt;
  assign w_shamt_ovf = ({1'b0, shamt} >= WIDTH_L);

  always_comb begin
    w_alu_result = '0;
    w_alu_flags  = '0;
    case (alu_op_e'(alu_control))
      OP_ADD: begin
        w_alu_result         = w_add[WIDTH-1:0];
        w_alu_flags[FLAG_C]  = w_add[WIDTH];
        w_alu_flags[FLAG_V]  = (a[WIDTH-1] == b[WIDTH-1]) &&
                               (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_result         = w_sub[WIDTH-1:0];
        // Top bit of the extended difference is the borrow.
        w_alu_flags[FLAG_C]  = ~w_sub[WIDTH];
        w_alu_flags[FLAG_V]  = (a[WIDTH-1] != b[WIDTH-1]) &&
                               (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_alu_result = a & b;
      OP_OR:  w_alu_result = a | b;
      OP_XOR: w_alu_result = a ^ b;
      OP_NEG: begin
        w_alu_result         = w_neg;
        w_alu_flags[FLAG_C]  = (a == '0);
        w_alu_flags[FLAG_V]  = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHIFT: begin
        if (w_shamt_ovf) begin
          w_alu_result = '0;
        end else if (direction) begin
          w_alu_result        = w_shr[WIDTH:1];
          w_alu_flags[FLAG_C] = w_shr[0];
        end else begin
          w_alu_result        = w_shl[WIDTH-1:0];
          w_alu_flags[FLAG_C] = w_shl[WIDTH];
        end
      end
      default: w_alu_result = '0;  // MUL yields zero when no multiplier built
    endcase
    w_alu_flags[FLAG_N] = w_alu_result[WIDTH-1];
    w_alu_flags[FLAG_Z] = (w_alu_result == '0);
  end

`ifdef ALU_SEQ_MUL_EN
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_is_mul = (alu_control == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) begin
          w_state_next = ST_DONE;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded only when an operation completes, so they hold
  // steady through DONE regardless of input activity.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
`ifdef ALU_SEQ_MUL_EN
    end else if (w_accept && !w_is_mul) begin
      r_result    <= w_alu_result;
      r_result_hi <= '0;
      r_flags     <= w_alu_flags;
    end else if ((r_state == ST_BUSY) && w_mul_done) begin
      r_result            <= w_mul_product[WIDTH-1:0];
      r_result_hi         <= w_mul_product[2*WIDTH-1:WIDTH];
      r_flags             <= '0;
      r_flags[FLAG_N]     <= w_mul_product[2*WIDTH-1];
      r_flags[FLAG_Z]     <= (w_mul_product == '0);
`else
    end else if (w_accept) begin
      r_result    <= w_alu_result;
      r_result_hi <= '0;
      r_flags     <= w_alu_flags;
`endif
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign alu_flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq at WIDTH = 5. Inputs change and
// outputs are sampled 1 time unit after the rising edge. The observation
// vector is {in_ready, out_valid, result, result_hi, alu_flags}.
// MUL expectations follow the ALU_SEQ_MUL_EN build option.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_control;
  logic [2:0]   shamt;
  logic         direction;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   alu_flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .shamt       (shamt),
    .direction   (direction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .alu_flags   (alu_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {in_ready, out_valid, result, result_hi, alu_flags};
  endfunction

  // Present one request for one accept edge, then scramble the operands so a
  // design that fails to capture at accept shows a wrong result.
  task automatic drive_op(input logic [2:0] op, input logic [4:0] va,
                          input logic [4:0] vb, input logic [2:0] sh,
                          input logic dir);
    alu_control = op; a = va; b = vb; shamt = sh; direction = dir;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 5'b10101; b = 5'b01011; shamt = 3'd2; direction = ~dir;
    alu_control = 3'b010;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    n_checks++;
    if (got !== 16'b1_0_00000_00000_0000) begin
      n_errors++;
      $display("FAIL reset_state got %b exp %b", got, 16'b1_0_00000_00000_0000);
    end
    reset = 1'b0;
    $display("reset: obs=%b", got);
  endtask

  // Vector layout: op[25:23] a[22:18] b[17:13] sh[12:10] dir[9] r[8:4] f[3:0]
  task automatic run_table(input string name, input logic [25:0] v);
    logic [15:0] got, exp;
    drive_op(v[25:23], v[22:18], v[17:13], v[12:10], v[9]);
    got = obs();
    exp = {1'b0, 1'b1, v[8:4], 5'b00000, v[3:0]};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s op=%b a=%b b=%b got %b exp %b", name, v[25:23],
               v[22:18], v[17:13], got, exp);
    end
    $display("%s: op=%b a=%b b=%b sh=%0d dir=%b -> obs=%b", name, v[25:23],
             v[22:18], v[17:13], v[12:10], v[9], got);
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL %s_return_idle got %b exp 10", name, {in_ready, out_valid});
    end
  endtask

  task automatic test_arith();
    logic [25:0] tbl [9];
    tbl = '{
      {3'b000, 5'b00011, 5'b00101, 3'd0, 1'b0, 5'b01000, 4'b0000},
      {3'b001, 5'b00101, 5'b00101, 3'd0, 1'b0, 5'b00000, 4'b0110},
      {3'b000, 5'b10000, 5'b10000, 3'd0, 1'b0, 5'b00000, 4'b0111},
      {3'b000, 5'b01111, 5'b00001, 3'd0, 1'b0, 5'b10000, 4'b1001},
      {3'b001, 5'b00011, 5'b00101, 3'd0, 1'b0, 5'b11110, 4'b1000},
      {3'b101, 5'b11001, 5'b00000, 3'd0, 1'b0, 5'b00111, 4'b0000},
      {3'b101, 5'b10000, 5'b00000, 3'd0, 1'b0, 5'b10000, 4'b1001},
      {3'b101, 5'b00000, 5'b00000, 3'd0, 1'b0, 5'b00000, 4'b0110},
      {3'b010, 5'b01100, 5'b01010, 3'd0, 1'b0, 5'b01000, 4'b0000}
    };
    for (int i = 0; i < 9; i++) run_table("arith", tbl[i]);
  endtask

  task automatic test_logic_shift();
    logic [25:0] tbl [9];
    tbl = '{
      {3'b011, 5'b01100, 5'b01010, 3'd0, 1'b0, 5'b01110, 4'b0000},
      {3'b100, 5'b01100, 5'b01010, 3'd0, 1'b0, 5'b00110, 4'b0000},
      {3'b110, 5'b00011, 5'b00000, 3'd1, 1'b0, 5'b00110, 4'b0000},
      {3'b110, 5'b00011, 5'b00000, 3'd1, 1'b1, 5'b00001, 4'b0010},
      {3'b110, 5'b10110, 5'b00000, 3'd1, 1'b0, 5'b01100, 4'b0010},
      {3'b110, 5'b11000, 5'b00000, 3'd4, 1'b1, 5'b00001, 4'b0010},
      {3'b110, 5'b10110, 5'b00000, 3'd0, 1'b1, 5'b10110, 4'b1000},
      {3'b110, 5'b11111, 5'b00000, 3'd5, 1'b0, 5'b00000, 4'b0100},
      {3'b110, 5'b11111, 5'b00000, 3'd7, 1'b1, 5'b00000, 4'b0100}
    };
    for (int i = 0; i < 9; i++) run_table("logic_shift", tbl[i]);
  endtask

  task automatic test_mul();
    logic [15:0] got;
`ifdef ALU_SEQ_MUL_EN
    drive_op(3'b111, 5'b00111, 5'b00110, 3'd0, 1'b0);
    // Five BUSY cycles after the accept edge: nothing ready, nothing valid.
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL mul_busy cycle %0d got %b exp 00", i, {in_ready, out_valid});
      end
      @(posedge clk); #1;
    end
    got = obs();
    n_checks++;
    if (got !== 16'b0_1_01010_00001_0000) begin
      n_errors++;
      $display("FAIL mul_result got %b exp %b", got, 16'b0_1_01010_00001_0000);
    end
`else
    drive_op(3'b111, 5'b00111, 5'b00110, 3'd0, 1'b0);
    got = obs();
    n_checks++;
    if (got !== 16'b0_1_00000_00000_0100) begin
      n_errors++;
      $display("FAIL mul_disabled got %b exp %b", got, 16'b0_1_00000_00000_0100);
    end
`endif
    $display("mul: a=00111 b=00110 -> obs=%b", got);
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL mul_return_idle got %b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got;
    out_ready = 1'b0;
    drive_op(3'b000, 5'b00011, 5'b00101, 3'd0, 1'b0);
    // A competing request during DONE must be ignored.
    alu_control = 3'b000; a = 5'b00001; b = 5'b00001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got = obs();
      n_checks++;
      if (got !== 16'b0_1_01000_00000_0000) begin
        n_errors++;
        $display("FAIL hold_done cycle %0d got %b exp %b", i, got,
                 16'b0_1_01000_00000_0000);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = obs();
    n_checks++;
    if (got !== 16'b0_1_01000_00000_0000) begin
      n_errors++;
      $display("FAIL hold_release got %b exp %b", got, 16'b0_1_01000_00000_0000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = obs();
    n_checks++;
    if (got !== 16'b1_0_01000_00000_0000) begin
      n_errors++;
      $display("FAIL backpressure_idle got %b exp %b", got, 16'b1_0_01000_00000_0000);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL no_queued_request got %b exp 10", {in_ready, out_valid});
    end
    $display("backpressure: released, obs=%b", obs());
  endtask

  task automatic test_reset_midop();
    logic [15:0] got;
    // Abandon a result waiting in DONE.
    out_ready = 1'b0;
    drive_op(3'b000, 5'b00011, 5'b00101, 3'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    got = obs();
    n_checks++;
    if (got !== 16'b1_0_00000_00000_0000) begin
      n_errors++;
      $display("FAIL reset_in_done got %b exp %b", got, 16'b1_0_00000_00000_0000);
    end
    $display("reset_in_done: obs=%b", got);
`ifdef ALU_SEQ_MUL_EN
    run_table("pre_busy_reset",
              {3'b000, 5'b00011, 5'b00101, 3'd0, 1'b0, 5'b01000, 4'b0000});
    drive_op(3'b111, 5'b11111, 5'b11111, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;  // third BUSY cycle
    @(posedge clk); #1;
    reset = 1'b0;
    got = obs();
    n_checks++;
    if (got !== 16'b1_0_00000_00000_0000) begin
      n_errors++;
      $display("FAIL reset_in_busy got %b exp %b", got, 16'b1_0_00000_00000_0000);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL abandoned_mul_pulse cycle %0d got %b exp 0", i, out_valid);
      end
    end
    $display("reset_in_busy: obs=%b", got);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_control = 3'b000; shamt = 3'd0; direction = 1'b0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 Derived localparam: SHW = $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 alu_control  input  3  opcode.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 direction  input  1  shift direction; 0 = left, 1 = right (logical).
REQ-012 out_valid  output  1  result/flags valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  WIDTH  result (low half for MUL).
REQ-015 result_hi  output  WIDTH  MUL upper half; 0 for all other ops.
REQ-016 alu_flags  output  4  {N,Z,C,V}.

Function
REQ-017 Opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 NEG (0-a), 110 SHIFT, 111 MUL (unsigned).
REQ-018 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-019 Accept = in_valid && in_ready; a, b, alu_control, shamt, direction SHALL be captured at accept; later input changes ignored.
REQ-020 Non-MUL ops: IDLE -> DONE on accept; out_valid asserted the cycle after accept (latency 1).
REQ-021 MUL: IDLE -> BUSY on accept; BUSY lasts exactly WIDTH cycles; then DONE (out_valid at accept+WIDTH+1).
REQ-022 DONE: result, result_hi, alu_flags, out_valid SHALL hold stable until out_ready = 1; out_valid && out_ready -> IDLE next cycle.
REQ-023 in_valid during BUSY/DONE SHALL be ignored; no request queuing.
REQ-024 N = result[WIDTH-1] (MUL: result_hi[WIDTH-1]); Z = 1 iff result (MUL: full 2*WIDTH product) is zero.
REQ-025 ADD: C = carry out, V = signed overflow. SUB: C = 1 iff a >= b unsigned (no borrow), V = signed overflow.
REQ-026 NEG: C = 1 iff a == 0; V = 1 iff a == 1 followed by WIDTH-1 zeros.
REQ-027 SHIFT: zero fill; C = last bit shifted out, 0 when shamt == 0; V = 0; shamt >= WIDTH SHALL yield result 0, C = 0.
REQ-028 AND/OR/XOR/MUL: C = 0, V = 0.

Reset
REQ-029 reset SHALL force IDLE, in_ready = 1, out_valid = 0, result = 0, result_hi = 0, alu_flags = 0 on the next rising edge.
REQ-030 reset during BUSY or DONE SHALL abandon the operation with no output handshake.

Configuration
REQ-031 Macro ALU_SEQ_MUL_EN defined: MUL per REQ-021.
REQ-032 ALU_SEQ_MUL_EN undefined: opcode 111 completes in 1 cycle with result 0, result_hi 0, flags 0100; no multiplier logic synthesised.

Structure
REQ-033 Package alu_seq_pkg SHALL hold opcode enum, FSM state enum, flag index constants (N=3, Z=2, C=1, V=0).
REQ-034 Iterative shift-add multiplier SHALL be sub-module alu_seq_mul (start, done, WIDTH-parametrised).

Verification (WIDTH = 5, out_ready = 1 unless stated)
REQ-035 ADD a=00011 b=00101 -> result 01000, flags 0000, out_valid 1 cycle after accept.
REQ-036 SUB a=00101 b=00101 -> result 00000, flags 0110; ADD a=10000 b=10000 -> result 00000, flags 0111.
REQ-037 SHIFT a=00011 shamt=1 direction=0 -> 00110, C=0; a=00011 shamt=1 direction=1 -> 00001, C=1; NEG a=11001 -> 00111, flags 0000.
REQ-038 MUL (macro defined) a=00111 b=00110 -> result 01010, result_hi 00001, flags 0000, out_valid at accept+6; in_ready 0 throughout.
REQ-039 out_ready held 0 for 3 cycles in DONE -> outputs stable, second in_valid ignored; release -> IDLE next cycle.
REQ-040 reset asserted in 3rd BUSY cycle of MUL -> next edge IDLE, all outputs 0, no out_valid pulse.
